// File: rtl/isr_dispatch_if.sv
// rtl/isr_dispatch_if.sv - CPU/IO signal bundle for isr_dispatch; ISR_DISPATCH_MASK_EN adds the mask input
interface isr_dispatch_if;
    logic [2:0] irq;
    logic       inta;
    logic       eoi;
`ifdef ISR_DISPATCH_MASK_EN
    logic [2:0] mask;
`endif
    logic       intr;
    logic       ld;
    logic [2:0] id;
    logic [2:0] in_service;
    logic       spur;

`ifdef ISR_DISPATCH_MASK_EN
    modport slave (
        input  irq, inta, eoi, mask,
        output intr, ld, id, in_service, spur
    );
    modport master (
        output irq, inta, eoi, mask,
        input  intr, ld, id, in_service, spur
    );
`else
    modport slave (
        input  irq, inta, eoi,
        output intr, ld, id, in_service, spur
    );
    modport master (
        output irq, inta, eoi,
        input  intr, ld, id, in_service, spur
    );
`endif
endinterface

// File: rtl/isr_dispatch.sv
// rtl/isr_dispatch.sv - 3-line priority interrupt dispatcher with nested in-service tracking; ISR_DISPATCH_MASK_EN enables per-line masking
module isr_dispatch (
    input  logic          clk,
    input  logic          reset,
    isr_dispatch_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [2:0] r_irq_q;
    logic [2:0] r_irr;
    logic [2:0] r_isr;
    logic [2:0] r_id;
    logic       r_ld;
    logic       r_spur;

    logic [2:0] w_edge;
    logic [2:0] w_mask;
    logic [2:0] w_above;
    logic [2:0] w_elig;
    logic [2:0] w_win;
    logic [2:0] w_grant_bit;
    logic [2:0] w_eoi_bit;
    logic       w_any_elig;
    logic       w_intr;
    logic       w_grant;
    logic       w_inta_spur;
    logic       w_eoi_spur;

    assign w_edge = bus.irq & ~r_irq_q;

`ifdef ISR_DISPATCH_MASK_EN
    assign w_mask = bus.mask;
`else
    assign w_mask = 3'b000;
`endif

    // Lines whose priority is strictly above the highest-priority in-service line
    always_comb begin
        w_above = 3'b111;
        if (r_isr[0])      w_above = 3'b000;
        else if (r_isr[1]) w_above = 3'b001;
        else if (r_isr[2]) w_above = 3'b011;
    end

    assign w_elig      = r_irr & ~w_mask & w_above;
    assign w_any_elig  = |w_elig;
    // Isolating the lowest set bit picks the highest-priority line
    assign w_win       = w_elig & (~w_elig + 3'd1);
    assign w_eoi_bit   = r_isr & (~r_isr + 3'd1);
    assign w_grant_bit = w_grant ? w_win : 3'b000;
    assign w_eoi_spur  = bus.eoi && (r_isr == 3'b000);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_elig) w_next = S_REQ;
            end
            S_REQ: begin
                if (bus.inta)        w_next = w_any_elig ? S_ACK : S_IDLE;
                else if (!w_any_elig) w_next = S_IDLE;
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: request to CPU, grant decision and spurious-inta detection
    always_comb begin
        w_intr      = 1'b0;
        w_grant     = 1'b0;
        w_inta_spur = 1'b0;
        case (r_state)
            S_REQ: begin
                w_intr = 1'b1;
                if (bus.inta) begin
                    w_grant     = w_any_elig;
                    w_inta_spur = !w_any_elig;
                end
            end
            default: begin
                w_inta_spur = bus.inta;
            end
        endcase
    end

    // Edge history, pending/in-service registers and registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q <= 3'b000;
            r_irr   <= 3'b000;
            r_isr   <= 3'b000;
            r_id    <= 3'b000;
            r_ld    <= 1'b0;
            r_spur  <= 1'b0;
        end else begin
            r_irq_q <= bus.irq;
            // A grant wins over a same-cycle edge on the granted line: that edge is a repeat
            r_irr   <= (r_irr | w_edge) & ~w_grant_bit;
            // eoi target comes from the pre-cycle ISR; a grant is always a strictly higher line
            r_isr   <= (r_isr & ~(bus.eoi ? w_eoi_bit : 3'b000)) | w_grant_bit;
            r_ld    <= w_grant;
            if (w_grant) begin
                r_id <= w_win;
            end
            r_spur  <= w_inta_spur | w_eoi_spur;
        end
    end

    assign bus.intr       = w_intr;
    assign bus.ld         = r_ld;
    assign bus.id         = r_id;
    assign bus.in_service = r_isr;
    assign bus.spur       = r_spur;

endmodule
